mem_ext_host_loader: RTL and testbench

- Host-side initiator for the cpu external memory ports (addr_ext/wen_ext/ren_ext/wdata_ext/rdata_ext and the *_2 data-memory set).
- Streams a program image into instruction memory and an initial image into data memory from a valid/ready input stream.
- Then asserts cpu enable for a programmed cycle count and streams a data-memory window back out on a valid/ready output stream.
- Sits between the testbench/host link and the cpu top; it is the writer/reader counterpart of the cpu's external slave ports.

---
 rtl/mem_ext_host_loader_pkg.sv | 48 ++++
 rtl/mem_ext_host_loader_ext_port_driver.sv | 37 +++
 rtl/mem_ext_host_loader.sv | 232 +++++++++++++++++++++++
 tb/tb_mem_ext_host_loader.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ext_host_loader_pkg.sv
// Shared definitions for the host loader: FSM state encoding, default word stride
// and the zero-length phase skipping helper.
package mem_ext_host_loader_pkg;

    localparam int ADDR_STEP_DEFAULT = 4;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD_I    = 3'd1,
        LOAD_D    = 3'd2,
        RUN       = 3'd3,
        DUMP_REQ  = 3'd4,
        DUMP_WAIT = 3'd5,
        DUMP_OUT  = 3'd6
    } state_t;

    // First phase at or after from_phase whose length is non-zero; IDLE when none remain.
    function automatic state_t first_active_phase(
        input state_t from_phase,
        input logic   imem_nz,
        input logic   dmem_nz,
        input logic   run_nz,
        input logic   dump_nz
    );
        logic   go_i;
        logic   go_d;
        logic   go_r;
        logic   go_o;
        state_t result;
        go_i = (from_phase == LOAD_I);
        go_d = go_i | (from_phase == LOAD_D);
        go_r = go_d | (from_phase == RUN);
        go_o = go_r | (from_phase == DUMP_REQ);
        if (go_i && imem_nz) begin
            result = LOAD_I;
        end else if (go_d && dmem_nz) begin
            result = LOAD_D;
        end else if (go_r && run_nz) begin
            result = RUN;
        end else if (go_o && dump_nz) begin
            result = DUMP_REQ;
        end else begin
            result = IDLE;
        end
        return result;
    endfunction

endpackage

// File: rtl/mem_ext_host_loader_ext_port_driver.sv
// Drives one cpu external memory port (addr/wen/ren/wdata) from a word index,
// a base address and the write/read requests; idle port outputs are all zero.
module mem_ext_host_loader_ext_port_driver
    import mem_ext_host_loader_pkg::*;
#(
    parameter int ADDR_STEP = ADDR_STEP_DEFAULT,
    parameter int LEN_W     = 16
) (
    input  logic [31:0]      base,
    input  logic [LEN_W-1:0] index,
    input  logic             wr_req,
    input  logic             rd_req,
    input  logic [31:0]      wr_data,
    output logic [31:0]      addr,
    output logic             wen,
    output logic             ren,
    output logic [31:0]      wdata
);

    logic [31:0] word_offset;

    always_comb begin
        word_offset = 32'(index) * 32'(ADDR_STEP);
        wen         = wr_req;
        // A write always wins so a port never sees read and write together.
        ren         = rd_req & ~wr_req;
        addr        = '0;
        wdata       = '0;
        if (wr_req || rd_req) begin
            addr = base + word_offset;
        end
        if (wr_req) begin
            wdata = wr_data;
        end
    end

endmodule

// File: rtl/mem_ext_host_loader.sv
// Host-side loader: streams imem/dmem images into the cpu ext ports, runs the cpu
// for a programmed cycle count, then streams a dmem window back out.
module mem_ext_host_loader
    import mem_ext_host_loader_pkg::*;
#(
    parameter int ADDR_STEP = ADDR_STEP_DEFAULT,
    parameter int RD_LAT    = 1,
    parameter int LEN_W     = 16
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] imem_len,
    input  logic [LEN_W-1:0] dmem_len,
    input  logic [LEN_W-1:0] run_cycles,
    input  logic [31:0]      dump_base,
    input  logic [LEN_W-1:0] dump_len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic             cpu_enable,
    output logic [31:0]      addr_ext,
    output logic             wen_ext,
    output logic             ren_ext,
    output logic [31:0]      wdata_ext,
    input  logic [31:0]      rdata_ext,
    output logic [31:0]      addr_ext_2,
    output logic             wen_ext_2,
    output logic             ren_ext_2,
    output logic [31:0]      wdata_ext_2,
    input  logic [31:0]      rdata_ext_2,
    output logic             busy,
    output logic             done
);

    state_t           state_reg;
    state_t           state_next;
    state_t           from_phase;
    logic [LEN_W-1:0] imem_len_reg;
    logic [LEN_W-1:0] dmem_len_reg;
    logic [LEN_W-1:0] run_cycles_reg;
    logic [LEN_W-1:0] dump_len_reg;
    logic [31:0]      dump_base_reg;
    logic [LEN_W-1:0] idx_reg;
    logic [LEN_W-1:0] idx_next;
    logic [LEN_W-1:0] idx_inc;
    logic [LEN_W-1:0] cnt_reg;
    logic [LEN_W-1:0] cnt_next;
    logic [31:0]      out_data_reg;
    logic [31:0]      out_data_next;
    logic             done_reg;
    logic             done_next;
    logic             cfg_load;
    logic             advance;
    logic [LEN_W-1:0] cfg_imem;
    logic [LEN_W-1:0] cfg_dmem;
    logic [LEN_W-1:0] cfg_run;
    logic [LEN_W-1:0] cfg_dump;
    logic             imem_wr;
    logic             dmem_wr;
    logic             dmem_rd;
    logic [31:0]      dmem_base;
    logic             unused_rdata_ext;

    assign unused_rdata_ext = ^rdata_ext;

    // While starting, phase skipping must look at the live inputs, not the stale registers.
    assign cfg_imem = cfg_load ? imem_len   : imem_len_reg;
    assign cfg_dmem = cfg_load ? dmem_len   : dmem_len_reg;
    assign cfg_run  = cfg_load ? run_cycles : run_cycles_reg;
    assign cfg_dump = cfg_load ? dump_len   : dump_len_reg;
    assign idx_inc  = idx_reg + LEN_W'(1);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_reg      <= IDLE;
            imem_len_reg   <= '0;
            dmem_len_reg   <= '0;
            run_cycles_reg <= '0;
            dump_len_reg   <= '0;
            dump_base_reg  <= '0;
            idx_reg        <= '0;
            cnt_reg        <= '0;
            out_data_reg   <= '0;
            done_reg       <= 1'b0;
        end else begin
            state_reg    <= state_next;
            idx_reg      <= idx_next;
            cnt_reg      <= cnt_next;
            out_data_reg <= out_data_next;
            done_reg     <= done_next;
            if (cfg_load) begin
                imem_len_reg   <= imem_len;
                dmem_len_reg   <= dmem_len;
                run_cycles_reg <= run_cycles;
                dump_len_reg   <= dump_len;
                dump_base_reg  <= dump_base;
            end
        end
    end

    always_comb begin
        state_next    = state_reg;
        idx_next      = idx_reg;
        cnt_next      = cnt_reg;
        out_data_next = out_data_reg;
        done_next     = 1'b0;
        cfg_load      = 1'b0;
        advance       = 1'b0;
        from_phase    = LOAD_I;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    cfg_load   = 1'b1;
                    advance    = 1'b1;
                    from_phase = LOAD_I;
                end
            end
            LOAD_I: begin
                if (in_valid) begin
                    if (idx_inc == imem_len_reg) begin
                        advance    = 1'b1;
                        from_phase = LOAD_D;
                    end else begin
                        idx_next = idx_inc;
                    end
                end
            end
            LOAD_D: begin
                if (in_valid) begin
                    if (idx_inc == dmem_len_reg) begin
                        advance    = 1'b1;
                        from_phase = RUN;
                    end else begin
                        idx_next = idx_inc;
                    end
                end
            end
            RUN: begin
                if (cnt_reg == '0) begin
                    advance    = 1'b1;
                    from_phase = DUMP_REQ;
                end else begin
                    cnt_next = cnt_reg - LEN_W'(1);
                end
            end
            DUMP_REQ: begin
                state_next = DUMP_WAIT;
                cnt_next   = LEN_W'(1);
            end
            DUMP_WAIT: begin
                if (cnt_reg >= LEN_W'(RD_LAT)) begin
                    out_data_next = rdata_ext_2;
                    state_next    = DUMP_OUT;
                end else begin
                    cnt_next = cnt_reg + LEN_W'(1);
                end
            end
            DUMP_OUT: begin
                if (out_ready) begin
                    if (idx_inc == dump_len_reg) begin
                        state_next = IDLE;
                        idx_next   = '0;
                        done_next  = 1'b1;
                    end else begin
                        state_next = DUMP_REQ;
                        idx_next   = idx_inc;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        // Entering a new phase: every phase restarts its word index at 0.
        if (advance) begin
            state_next = first_active_phase(from_phase, cfg_imem != '0, cfg_dmem != '0,
                                            cfg_run != '0, cfg_dump != '0);
            idx_next   = '0;
            cnt_next   = cfg_run - LEN_W'(1);
            if (state_next == IDLE) begin
                done_next = 1'b1;
            end
        end
    end

    assign in_ready   = (state_reg == LOAD_I) || (state_reg == LOAD_D);
    assign cpu_enable = (state_reg == RUN);
    assign out_valid  = (state_reg == DUMP_OUT);
    assign out_data   = out_data_reg;
    assign busy       = (state_reg != IDLE);
    assign done       = done_reg;

    assign imem_wr   = (state_reg == LOAD_I) && in_valid;
    assign dmem_wr   = (state_reg == LOAD_D) && in_valid;
    assign dmem_rd   = (state_reg == DUMP_REQ);
    assign dmem_base = dmem_rd ? dump_base_reg : 32'h0;

    mem_ext_host_loader_ext_port_driver #(
        .ADDR_STEP (ADDR_STEP),
        .LEN_W     (LEN_W)
    ) u_imem_port (
        .base    (32'h0),
        .index   (idx_reg),
        .wr_req  (imem_wr),
        .rd_req  (1'b0),
        .wr_data (in_data),
        .addr    (addr_ext),
        .wen     (wen_ext),
        .ren     (ren_ext),
        .wdata   (wdata_ext)
    );

    mem_ext_host_loader_ext_port_driver #(
        .ADDR_STEP (ADDR_STEP),
        .LEN_W     (LEN_W)
    ) u_dmem_port (
        .base    (dmem_base),
        .index   (idx_reg),
        .wr_req  (dmem_wr),
        .rd_req  (dmem_rd),
        .wr_data (in_data),
        .addr    (addr_ext_2),
        .wen     (wen_ext_2),
        .ren     (ren_ext_2),
        .wdata   (wdata_ext_2)
    );

endmodule

// File: tb/tb_mem_ext_host_loader.sv
// Directed bench for mem_ext_host_loader: scoreboarded port writes/reads and dump words,
// plus reset, run-length, stall, abort and zero-length sessions.
module tb_mem_ext_host_loader;

    localparam int LEN_W = 16;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic             clk = 1'b0;
    logic             arst_n;
    logic             start;
    logic [LEN_W-1:0] imem_len;
    logic [LEN_W-1:0] dmem_len;
    logic [LEN_W-1:0] run_cycles;
    logic [31:0]      dump_base;
    logic [LEN_W-1:0] dump_len;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_data;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_data;
    logic             cpu_enable;
    logic [31:0]      addr_ext;
    logic             wen_ext;
    logic             ren_ext;
    logic [31:0]      wdata_ext;
    logic [31:0]      rdata_ext;
    logic [31:0]      addr_ext_2;
    logic             wen_ext_2;
    logic             ren_ext_2;
    logic [31:0]      wdata_ext_2;
    logic [31:0]      rdata_ext_2;
    logic             busy;
    logic             done;

    logic [31:0] dmem [0:63];
    wr_t         exp_imem_q[$];
    wr_t         exp_dmem_q[$];
    wr_t         obs_imem_q[$];
    wr_t         obs_dmem_q[$];
    logic [31:0] exp_rd_q[$];
    logic [31:0] obs_rd_q[$];
    logic [31:0] exp_dump_q[$];
    int          en_total = 0;
    int          clash_total = 0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    assign rdata_ext = 32'hDEAD_BEEF;

    mem_ext_host_loader dut (
        .clk         (clk),
        .arst_n      (arst_n),
        .start       (start),
        .imem_len    (imem_len),
        .dmem_len    (dmem_len),
        .run_cycles  (run_cycles),
        .dump_base   (dump_base),
        .dump_len    (dump_len),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .cpu_enable  (cpu_enable),
        .addr_ext    (addr_ext),
        .wen_ext     (wen_ext),
        .ren_ext     (ren_ext),
        .wdata_ext   (wdata_ext),
        .rdata_ext   (rdata_ext),
        .addr_ext_2  (addr_ext_2),
        .wen_ext_2   (wen_ext_2),
        .ren_ext_2   (ren_ext_2),
        .wdata_ext_2 (wdata_ext_2),
        .rdata_ext_2 (rdata_ext_2),
        .busy        (busy),
        .done        (done)
    );

    // Data memory with one cycle of read latency; stale cycles return a marker value.
    always @(posedge clk) begin
        if (ren_ext_2) begin
            rdata_ext_2 <= dmem[addr_ext_2[7:2]];
        end else begin
            rdata_ext_2 <= 32'hBADB_AD00;
        end
    end

    // Port monitor: logs every observed transaction for the scoreboard.
    always @(negedge clk) begin
        if (cpu_enable) en_total <= en_total + 1;
        if ((ren_ext && wen_ext) || (ren_ext_2 && wen_ext_2)) clash_total <= clash_total + 1;
        if (wen_ext) obs_imem_q.push_back({addr_ext, wdata_ext});
        if (wen_ext_2) obs_dmem_q.push_back({addr_ext_2, wdata_ext_2});
        if (ren_ext_2) obs_rd_q.push_back(addr_ext_2);
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic drain_scoreboard(input string tag);
        check({tag, "_imem_wr_count"}, 32'(obs_imem_q.size()), 32'(exp_imem_q.size()));
        for (int i = 0; i < exp_imem_q.size() && i < obs_imem_q.size(); i++) begin
            check({tag, "_imem_addr"}, obs_imem_q[i].addr, exp_imem_q[i].addr);
            check({tag, "_imem_data"}, obs_imem_q[i].data, exp_imem_q[i].data);
        end
        check({tag, "_dmem_wr_count"}, 32'(obs_dmem_q.size()), 32'(exp_dmem_q.size()));
        for (int i = 0; i < exp_dmem_q.size() && i < obs_dmem_q.size(); i++) begin
            check({tag, "_dmem_addr"}, obs_dmem_q[i].addr, exp_dmem_q[i].addr);
            check({tag, "_dmem_data"}, obs_dmem_q[i].data, exp_dmem_q[i].data);
        end
        check({tag, "_rd_count"}, 32'(obs_rd_q.size()), 32'(exp_rd_q.size()));
        for (int i = 0; i < exp_rd_q.size() && i < obs_rd_q.size(); i++) begin
            check({tag, "_rd_addr"}, obs_rd_q[i], exp_rd_q[i]);
        end
        exp_imem_q.delete();
        obs_imem_q.delete();
        exp_dmem_q.delete();
        obs_dmem_q.delete();
        exp_rd_q.delete();
        obs_rd_q.delete();
    endtask

    initial begin
        int          en_base;
        int          cyc;
        int          busy_low;
        int          k;
        int          stall;
        logic [31:0] word;
        logic [31:0] exp_word;

        for (int i = 0; i < 64; i++) dmem[i] = 32'h0;
        dmem[4] = 32'h11;
        dmem[5] = 32'h22;
        dmem[6] = 32'h33;

        // Reset held with start and in_valid asserted.
        arst_n     = 1'b0;
        start      = 1'b1;
        in_valid   = 1'b1;
        in_data    = 32'hCAFE_0001;
        imem_len   = 16'd3;
        dmem_len   = 16'd2;
        run_cycles = 16'd5;
        dump_base  = 32'h0;
        dump_len   = 16'd1;
        out_ready  = 1'b1;
        repeat (3) step();
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd0);
        check("rst_cpu_enable", {31'b0, cpu_enable}, 32'd0);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_addr_ext", addr_ext, 32'd0);
        check("rst_addr_ext_2", addr_ext_2, 32'd0);
        start     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        arst_n = 1'b1;
        step();
        check("post_rst_busy", {31'b0, busy}, 32'd0);
        drain_scoreboard("reset");

        // Load 3 imem + 2 dmem words with gaps; a second start mid-LOAD_I must be ignored.
        en_base    = en_total;
        imem_len   = 16'd3;
        dmem_len   = 16'd2;
        run_cycles = 16'd0;
        dump_len   = 16'd0;
        dump_base  = 32'h100;
        pulse_start();
        check("load_busy", {31'b0, busy}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            word = 32'hA000_0000 + 32'(i);
            if (i < 3) exp_imem_q.push_back({32'(i * 4), word});
            else       exp_dmem_q.push_back({32'((i - 3) * 4), word});
            in_valid = 1'b1;
            in_data  = word;
            cyc = 0;
            while (!in_ready && cyc < 20) begin
                step();
                cyc++;
            end
            check("load_in_ready", {31'b0, in_ready}, 32'd1);
            step();
            in_valid = 1'b0;
            in_data  = 32'hFFFF_FFFF;
            if (i == 0) begin
                imem_len = 16'd7;
                pulse_start();
                imem_len = 16'd3;
            end
            if (i == 1 || i == 3) repeat (2) step();
        end
        check("load_done", {31'b0, done}, 32'd1);
        check("load_idle", {31'b0, busy}, 32'd0);
        step();
        check("load_done_pulse", {31'b0, done}, 32'd0);
        check("load_cpu_enable", 32'(en_total - en_base), 32'd0);
        drain_scoreboard("load");

        // Run only: cpu_enable exactly run_cycles cycles.
        en_base    = en_total;
        imem_len   = 16'd0;
        dmem_len   = 16'd0;
        run_cycles = 16'd5;
        dump_len   = 16'd0;
        pulse_start();
        cyc      = 0;
        busy_low = 0;
        while (!done && cyc < 50) begin
            if (!busy) busy_low++;
            step();
            cyc++;
        end
        check("run_done_latency", 32'(cyc), 32'd5);
        check("run_enable_cycles", 32'(en_total - en_base), 32'd5);
        check("run_busy", 32'(busy_low), 32'd0);
        check("run_enable_off", {31'b0, cpu_enable}, 32'd0);
        drain_scoreboard("run");

        // Dump 3 words from 0x10 with a 4-cycle stall on the second word.
        run_cycles = 16'd0;
        dump_base  = 32'h10;
        dump_len   = 16'd3;
        exp_rd_q.push_back(32'h10);
        exp_rd_q.push_back(32'h14);
        exp_rd_q.push_back(32'h18);
        exp_dump_q.push_back(32'h11);
        exp_dump_q.push_back(32'h22);
        exp_dump_q.push_back(32'h33);
        pulse_start();
        k     = 0;
        stall = 0;
        cyc   = 0;
        while (k < 3 && cyc < 100) begin
            if (out_valid && k == 1 && stall < 4) begin
                check("dump_stall_data", out_data, 32'h22);
                stall++;
                step();
            end else if (out_valid) begin
                exp_word = exp_dump_q.pop_front();
                check("dump_data", out_data, exp_word);
                out_ready = 1'b1;
                step();
                out_ready = 1'b0;
                k++;
            end else begin
                step();
            end
            cyc++;
        end
        check("dump_words", 32'(k), 32'd3);
        check("dump_stall_cycles", 32'(stall), 32'd4);
        check("dump_done", {31'b0, done}, 32'd1);
        step();
        check("dump_done_pulse", {31'b0, done}, 32'd0);
        drain_scoreboard("dump");

        // Abort mid-RUN with asynchronous reset.
        dump_len   = 16'd0;
        run_cycles = 16'd20;
        pulse_start();
        repeat (2) step();
        check("abort_run_active", {31'b0, cpu_enable}, 32'd1);
        arst_n = 1'b0;
        #1;
        check("abort_cpu_enable", {31'b0, cpu_enable}, 32'd0);
        check("abort_busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        arst_n = 1'b1;
        step();
        check("abort_idle", {31'b0, busy}, 32'd0);
        check("abort_no_done", {31'b0, done}, 32'd0);
        drain_scoreboard("abort");

        // All-zero session: done exactly one cycle after start, no port activity.
        run_cycles = 16'd0;
        pulse_start();
        check("zero_done", {31'b0, done}, 32'd1);
        check("zero_busy", {31'b0, busy}, 32'd0);
        step();
        check("zero_done_pulse", {31'b0, done}, 32'd0);
        drain_scoreboard("zero");
        check("port_rw_clash", 32'(clash_total), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
